hilo_muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair. The single-cycle ALU keeps add/sub/logic/shift/slt; this block takes MULT/MULTU/DIV/DIVU off the ALU's critical path. It runs radix-2 shift-add multiply and restoring divide over WIDTH iterations, and presents a start/busy/done handshake to the pipeline stall logic. It also services direct HI/LO writes.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 19 +
 rtl/hilo_muldiv_ctrl_if.sv | 29 ++
 rtl/hilo_muldiv_ctrl.sv | 139 +++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer and the instruction decoder.
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Pipeline-facing request/result bundle of the HI/LO multiply/divide sequencer.
interface hilo_muldiv_ctrl_if
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdx;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rda, rdx, wr_hi, wr_lo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rda, rdx, wr_hi, wr_lo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO pair.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, one step per clock.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  state_e             state_r, state_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   acc_hi_r, acc_lo_r, opa_r, opb_r, hi_r, lo_r;
  logic               neg_q_r, neg_r_r, is_div_r;
  logic               busy_r, done_r, dbz_r;
  logic               idle_s, accept_s, is_div_op_s, is_signed_s, dbz_start_s, borrow_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s, res_hi_s, res_lo_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s;

  assign idle_s      = (state_r == S_IDLE) || (state_r == S_DONE);
  assign accept_s    = idle_s && bus.start;
  assign is_div_op_s = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign is_signed_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign dbz_start_s = is_div_op_s && (bus.rdx == {WIDTH{1'b0}});
  assign abs_a_s     = (is_signed_s && bus.rda[WIDTH-1]) ? -bus.rda : bus.rda;
  assign abs_b_s     = (is_signed_s && bus.rdx[WIDTH-1]) ? -bus.rdx : bus.rdx;

  // acc_hi holds the product high half or the partial remainder; acc_lo the multiplier or quotient
  assign mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opb_r};
  assign borrow_s    = div_diff_s[WIDTH];

  assign prod_s   = neg_q_r ? -{acc_hi_r, acc_lo_r} : {acc_hi_r, acc_lo_r};
  assign res_hi_s = is_div_r ? (neg_r_r ? -acc_hi_r : acc_hi_r) : prod_s[2*WIDTH-1:WIDTH];
  assign res_lo_s = is_div_r ? (neg_q_r ? -acc_lo_r : acc_lo_r) : prod_s[WIDTH-1:0];

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (!accept_s)        state_s = S_IDLE;
        else if (dbz_start_s) state_s = S_DONE;
        else if (is_div_op_s) state_s = S_DIV;
        else                  state_s = S_MUL;
      end
      S_MUL, S_DIV: state_s = (cnt_r == CNT_ZERO) ? S_FIX : state_r;
      S_FIX:        state_s = S_DONE;
      default:      state_s = S_IDLE;
    endcase
  end

  // State register with registered busy/done handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == S_MUL) || (state_s == S_DIV) || (state_s == S_FIX);
      done_r  <= (state_s == S_DONE);
    end
  end

  // Iteration datapath and architectural HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= CNT_ZERO;
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
      opa_r    <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      is_div_r <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      if (idle_s && bus.wr_hi) hi_r <= bus.wr_data;
      if (idle_s && bus.wr_lo) lo_r <= bus.wr_data;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            opa_r    <= abs_a_s;
            opb_r    <= abs_b_s;
            neg_q_r  <= is_signed_s && (bus.rda[WIDTH-1] ^ bus.rdx[WIDTH-1]);
            neg_r_r  <= is_signed_s && bus.rda[WIDTH-1];
            is_div_r <= is_div_op_s;
            cnt_r    <= CNT_LAST;
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= is_div_op_s ? abs_a_s : abs_b_s;
            // Divide by zero finishes immediately and wins over a same-edge direct write
            if (dbz_start_s) begin
              hi_r  <= bus.rda;
              lo_r  <= {WIDTH{1'b1}};
              dbz_r <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_hi_r <= mul_sum_s[WIDTH:1];
          acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
          cnt_r    <= cnt_r - CNT_ONE;
        end
        S_DIV: begin
          acc_hi_r <= borrow_s ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
          acc_lo_r <= {acc_lo_r[WIDTH-2:0], ~borrow_s};
          cnt_r    <= cnt_r - CNT_ONE;
        end
        S_FIX: begin
          hi_r  <= res_hi_s;
          lo_r  <= res_lo_s;
          dbz_r <= 1'b0;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench: directed literal cases plus randomized traffic against a cycle-level arithmetic model.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   cmp_en = 1'b0;

  hilo_muldiv_ctrl_if #(.WIDTH(W)) ifc ();
  hilo_muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  always #5 clk = ~clk;

  // Model: remaining busy cycles plus the pending result computed with plain arithmetic
  typedef struct {
    int           left;
    logic [W-1:0] hi, lo, ph, pl;
    logic         dbz, done;
  } model_t;
  model_t m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic op_e to_op(input logic [1:0] v);
    return op_e'(v);
  endfunction

  function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, b,
                                 output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; z = 1'b1; end
        else begin l = 32'(sa / sb); h = 32'(sa % sb); end
      end
      default: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; z = 1'b1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  function automatic model_t model_next(input model_t c);
    model_t n;
    logic [W-1:0] h, l;
    logic z;
    n = c;
    n.done = 1'b0;
    if (rst) begin
      n.left = 0; n.hi = '0; n.lo = '0; n.dbz = 1'b0;
    end else if (c.left > 0) begin
      n.left = c.left - 1;
      if (n.left == 0) begin
        n.hi = c.ph; n.lo = c.pl; n.dbz = 1'b0; n.done = 1'b1;
      end
    end else begin
      if (ifc.wr_hi) n.hi = ifc.wr_data;
      if (ifc.wr_lo) n.lo = ifc.wr_data;
      if (ifc.start) begin
        ref_op(ifc.op, ifc.rda, ifc.rdx, h, l, z);
        if (z) begin
          n.hi = h; n.lo = l; n.dbz = 1'b1; n.done = 1'b1;
        end else begin
          n.left = W + 1; n.ph = h; n.pl = l;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", ifc.busy, m.left > 0);
      chk("done", ifc.done, m.done);
      chk("dbz", ifc.div_by_zero, m.dbz);
      chk("hi", ifc.hi, m.hi);
      chk("lo", ifc.lo, m.lo);
    end
  end

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (ifc.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input bit now, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ez, input int elat);
    int lat;
    if (!now) @(negedge clk);
    ifc.start = 1'b1; ifc.op = to_op(o); ifc.rda = a; ifc.rdx = b;
    @(negedge clk);
    ifc.start = 1'b0; ifc.rda = $urandom; ifc.rdx = $urandom; ifc.op = to_op(2'($urandom));
    wait_done(1, lat);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_hi"}, ifc.hi, eh);
    chk({nm, "_lo"}, ifc.lo, el);
    chk({nm, "_dbz"}, ifc.div_by_zero, ez);
  endtask

  initial begin
    int lat;
    logic [1:0] sel;
    ifc.start = 1'b0; ifc.op = OP_MULT; ifc.rda = '0; ifc.rdx = '0;
    ifc.wr_hi = 1'b0; ifc.wr_lo = 1'b0; ifc.wr_data = '0;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_hi", ifc.hi, 32'd0);
    chk("rst_lo", ifc.lo, 32'd0);
    rst = 1'b0;

    run_op("multu_5x3", 1'b0, 2'b01, 32'd5, 32'd3, 32'd0, 32'd15, 1'b0, 34);
    run_op("mult_m1x2", 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
    run_op("multu_max", 1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
    run_op("divu_10_2", 1'b0, 2'b11, 32'd10, 32'd2, 32'd0, 32'd5, 1'b0, 34);
    run_op("div_m7_2", 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("div_ovf", 1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);
    run_op("div_by0", 1'b0, 2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("multu_7x6", 1'b0, 2'b01, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 34);

    // Start and direct write during busy must both be dropped
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = OP_MULTU; ifc.rda = 32'd5; ifc.rdx = 32'd3;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    ifc.start = 1'b1; ifc.op = OP_DIVU; ifc.rda = 32'd9; ifc.rdx = 32'd3;
    ifc.wr_hi = 1'b1; ifc.wr_data = 32'h0000_AAAA;
    @(negedge clk);
    ifc.start = 1'b0; ifc.wr_hi = 1'b0;
    wait_done(5, lat);
    chk("ign_lat", lat, 34);
    chk("ign_hi", ifc.hi, 32'd0);
    chk("ign_lo", ifc.lo, 32'd15);
    ifc.wr_lo = 1'b1; ifc.wr_data = 32'h0000_0055;
    @(negedge clk);
    ifc.wr_lo = 1'b0;
    chk("wr_lo", ifc.lo, 32'h0000_0055);

    // Reset in the tenth busy cycle discards the operation
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = OP_MULT; ifc.rda = 32'd3; ifc.rdx = 32'hFFFF_FFFB;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", ifc.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", ifc.busy, 1'b0);
    chk("mid_rst_done", ifc.done, 1'b0);
    chk("mid_rst_hi", ifc.hi, 32'd0);
    chk("mid_rst_lo", ifc.lo, 32'd0);
    chk("mid_rst_dbz", ifc.div_by_zero, 1'b0);
    run_op("divu_100_7", 1'b0, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);

    // Randomized traffic, including back-to-back starts, zero divisors and rare resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ifc.start = ($urandom_range(0, 3) == 0);
      ifc.op = to_op(2'($urandom));
      sel = 2'($urandom);
      ifc.rda = (sel == 2'd0) ? 32'h8000_0000 : (sel == 2'd1) ? 32'($urandom_range(0, 20)) : $urandom;
      sel = 2'($urandom);
      ifc.rdx = (sel == 2'd0) ? 32'd0 : (sel == 2'd1) ? 32'hFFFF_FFFF :
                (sel == 2'd2) ? 32'($urandom_range(1, 9)) : $urandom;
      ifc.wr_hi = ($urandom_range(0, 7) == 0);
      ifc.wr_lo = ($urandom_range(0, 7) == 0);
      ifc.wr_data = $urandom;
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    ifc.start = 1'b0; ifc.wr_hi = 1'b0; ifc.wr_lo = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
